// File: rtl/rans_word_packer.sv
// rans_word_packer
//   Packs the time-multiplexed byte stream of an interleaved rANS encoder into
//   per-lane OUT_WIDTH words (first byte in the LSBs) and queues completed
//   words in a shared output FIFO. A flush drains every lane's partial word
//   and closes the stream with a terminator word from the highest lane.
//
// Ports
//   clk_i, rst_i       clock, asynchronous active-high reset
//   valid_i            enc_i/lane_i carry a byte this cycle
//   enc_i, lane_i      encoded byte and its producing lane
//   flush_i            single-cycle request to drain all partial words
//   m_valid_o          FIFO head valid
//   m_ready_i          consumer accepts head
//   m_data_o           packed word
//   m_lane_o           lane of the word
//   m_bytes_o          number of valid bytes in m_data_o (0..BPW)
//   m_last_o           final word of a flush
//   busy_o             flush in progress
//   overflow_o         sticky: a byte or word was dropped
module rans_word_packer #(
  parameter int SYMBOL_WIDTH = 8,
  parameter int NUM_RANS     = 4,
  parameter int OUT_WIDTH    = 32,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        valid_i,
  input  logic [SYMBOL_WIDTH-1:0]                     enc_i,
  input  logic [$clog2(NUM_RANS)-1:0]                 lane_i,
  input  logic                                        flush_i,
  output logic                                        m_valid_o,
  input  logic                                        m_ready_i,
  output logic [OUT_WIDTH-1:0]                        m_data_o,
  output logic [$clog2(NUM_RANS)-1:0]                 m_lane_o,
  output logic [$clog2(OUT_WIDTH/SYMBOL_WIDTH):0]     m_bytes_o,
  output logic                                        m_last_o,
  output logic                                        busy_o,
  output logic                                        overflow_o
);

  localparam int LANE_W  = $clog2(NUM_RANS);
  localparam int BPW     = OUT_WIDTH / SYMBOL_WIDTH;
  localparam int CNT_W   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int BYTES_W = $clog2(BPW) + 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(BPW - 1);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_RANS - 1);
  localparam logic [PTR_W:0]    OCC_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_FLUSH
  } state_t;

  state_t              state_q;
  logic [LANE_W-1:0]   ptr_q;
  logic [OUT_WIDTH-1:0] word_q [NUM_RANS];
  logic [CNT_W-1:0]    cnt_q  [NUM_RANS];

  // Output FIFO storage (not reset; head outputs are gated by m_valid_o)
  logic [OUT_WIDTH-1:0] fifo_data  [FIFO_DEPTH];
  logic [LANE_W-1:0]    fifo_lane  [FIFO_DEPTH];
  logic [BYTES_W-1:0]   fifo_bytes [FIFO_DEPTH];
  logic                 fifo_last  [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_q, rd_q;
  logic [PTR_W:0]       occ_q;

  logic                 full, pop, room;
  logic                 push_req, push_ok, push_last, flush_skip;
  logic [OUT_WIDTH-1:0] push_data, merged;
  logic [LANE_W-1:0]    push_lane;
  logic [BYTES_W-1:0]   push_bytes;

  assign full      = (occ_q == OCC_FULL);
  assign m_valid_o = (occ_q != '0);
  assign pop       = m_valid_o && m_ready_i;
  // A pop in the same cycle frees the slot the push needs
  assign room      = !full || pop;
  assign push_ok   = push_req && room;

  assign m_data_o  = m_valid_o ? fifo_data[rd_q]  : '0;
  assign m_lane_o  = m_valid_o ? fifo_lane[rd_q]  : '0;
  assign m_bytes_o = m_valid_o ? fifo_bytes[rd_q] : '0;
  assign m_last_o  = m_valid_o ? fifo_last[rd_q]  : 1'b0;

  always_comb begin
    push_req   = 1'b0;
    push_data  = '0;
    push_lane  = '0;
    push_bytes = '0;
    push_last  = 1'b0;
    merged     = word_q[lane_i];
    merged[int'(cnt_q[lane_i]) * SYMBOL_WIDTH +: SYMBOL_WIDTH] = enc_i;
    // The last lane is never skipped: it carries the terminator
    flush_skip = (ptr_q != LANE_LAST) && (cnt_q[ptr_q] == '0);
    if (state_q == ST_IDLE) begin
      if (valid_i && (cnt_q[lane_i] == CNT_MAX)) begin
        push_req   = 1'b1;
        push_data  = merged;
        push_lane  = lane_i;
        push_bytes = BYTES_W'(BPW);
      end
    end else if (!flush_skip) begin
      // Word registers are cleared on every push, so unused bytes are zero
      push_req   = 1'b1;
      push_data  = word_q[ptr_q];
      push_lane  = ptr_q;
      push_bytes = BYTES_W'(cnt_q[ptr_q]);
      push_last  = (ptr_q == LANE_LAST);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      fifo_data[wr_q]  <= push_data;
      fifo_lane[wr_q]  <= push_lane;
      fifo_bytes[wr_q] <= push_bytes;
      fifo_last[wr_q]  <= push_last;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      busy_o     <= 1'b0;
      overflow_o <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      occ_q      <= '0;
      for (int unsigned l = 0; l < NUM_RANS; l++) begin
        word_q[l] <= '0;
        cnt_q[l]  <= '0;
      end
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
      // Only IDLE word completion drops; a flush stalls instead
      if (push_req && !room && (state_q == ST_IDLE)) overflow_o <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            if (cnt_q[lane_i] == CNT_MAX) begin
              cnt_q[lane_i]  <= '0;
              word_q[lane_i] <= '0;
            end else begin
              cnt_q[lane_i]  <= cnt_q[lane_i] + 1'b1;
              word_q[lane_i] <= merged;
            end
          end
          if (flush_i) begin
            state_q <= ST_FLUSH;
            ptr_q   <= '0;
            busy_o  <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (valid_i) overflow_o <= 1'b1;
          if (flush_skip) begin
            ptr_q <= ptr_q + 1'b1;
          end else if (room) begin
            cnt_q[ptr_q]  <= '0;
            word_q[ptr_q] <= '0;
            if (ptr_q == LANE_LAST) begin
              state_q <= ST_IDLE;
              busy_o  <= 1'b0;
              ptr_q   <= '0;
            end else begin
              ptr_q <= ptr_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rans_word_packer.sv
// tb_rans_word_packer
//   Scoreboard bench for rans_word_packer with default parameters
//   (8-bit bytes, 4 lanes, 32-bit words, 16-entry FIFO).
module tb_rans_word_packer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [7:0]  enc_i = '0;
  logic [1:0]  lane_i = '0;
  logic        flush_i = 1'b0;
  logic        m_valid_o;
  logic        m_ready_i = 1'b0;
  logic [31:0] m_data_o;
  logic [1:0]  m_lane_o;
  logic [2:0]  m_bytes_o;
  logic        m_last_o;
  logic        busy_o;
  logic        overflow_o;

  rans_word_packer #(
    .SYMBOL_WIDTH(8),
    .NUM_RANS(4),
    .OUT_WIDTH(32),
    .FIFO_DEPTH(16)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .valid_i(valid_i),
    .enc_i(enc_i),
    .lane_i(lane_i),
    .flush_i(flush_i),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i),
    .m_data_o(m_data_o),
    .m_lane_o(m_lane_o),
    .m_bytes_o(m_bytes_o),
    .m_last_o(m_last_o),
    .busy_o(busy_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  lane;
    logic [2:0]  bytes;
    logic        last;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] model_word [4];
  int          model_cnt  [4];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input int lane, input int nb, input logic last);
    exp_t e;
    e.data  = d;
    e.lane  = 2'(lane);
    e.bytes = 3'(nb);
    e.last  = last;
    q.push_back(e);
  endtask

  task automatic model_clear();
    q.delete();
    for (int l = 0; l < 4; l++) begin
      model_word[l] = '0;
      model_cnt[l]  = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one byte; the model forms the expected word when a lane fills.
  // With the consumer stalled, a 17th outstanding word cannot be stored.
  task automatic send_byte(input int lane, input logic [7:0] b);
    valid_i = 1'b1;
    enc_i   = b;
    lane_i  = 2'(lane);
    model_word[lane][model_cnt[lane]*8 +: 8] = b;
    model_cnt[lane]++;
    if (model_cnt[lane] == 4) begin
      if (!(m_ready_i == 1'b0 && q.size() >= 16))
        push_exp(model_word[lane], lane, 4, 1'b0);
      model_word[lane] = '0;
      model_cnt[lane]  = 0;
    end
    tick();
    valid_i = 1'b0;
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    for (int l = 0; l < 4; l++) begin
      if (l == 3 || model_cnt[l] != 0)
        push_exp(model_word[l], l, model_cnt[l], l == 3);
      model_word[l] = '0;
      model_cnt[l]  = 0;
    end
    tick();
    flush_i = 1'b0;
  endtask

  task automatic wait_not_busy(input string tag);
    int n = 0;
    while (busy_o && n < 50) begin
      tick();
      n++;
    end
    check(tag, busy_o, 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    model_clear();
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // Monitor: compare the head against the scoreboard when a transfer is due
  always @(negedge clk_i) begin
    if (!rst_i && m_valid_o && m_ready_i) begin
      if (q.size() == 0) begin
        check("spurious_word", m_valid_o, 0);
      end else begin
        mon_e = q.pop_front();
        check("m_data",  m_data_o,  mon_e.data);
        check("m_lane",  m_lane_o,  mon_e.lane);
        check("m_bytes", m_bytes_o, mon_e.bytes);
        check("m_last",  m_last_o,  mon_e.last);
      end
    end
  end

  initial begin
    model_clear();
    #1;
    check("rst_valid", m_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_data", m_data_o, 0);
    tick();
    rst_i = 1'b0;
    tick();

    // Single word on lane 0, one-cycle latency
    m_ready_i = 1'b1;
    send_byte(0, 8'h11);
    send_byte(0, 8'h22);
    send_byte(0, 8'h33);
    check("t1_not_yet", m_valid_o, 0);
    send_byte(0, 8'h44);
    check("t1_latency", m_valid_o, 1);
    repeat (3) tick();
    check("t1_drained", q.size(), 0);

    // Round-robin lanes, 8 bytes each
    for (int i = 0; i < 32; i++) send_byte(i % 4, 8'(i));
    repeat (4) tick();
    check("t2_drained", q.size(), 0);
    check("t2_no_ovf", overflow_o, 0);

    // Partial lane 1 then flush: lane 1 word then lane 3 terminator
    send_byte(1, 8'hAA);
    send_byte(1, 8'hBB);
    do_flush();
    check("t3_busy", busy_o, 1);
    wait_not_busy("t3_busy_fall");
    repeat (3) tick();
    check("t3_drained", q.size(), 0);

    // Stalled consumer, 17 words: 16 kept, last dropped
    m_ready_i = 1'b0;
    for (int i = 0; i < 68; i++) send_byte(2, 8'(i + 8'h40));
    check("t4_valid", m_valid_o, 1);
    check("t4_ovf", overflow_o, 1);
    check("t4_queued", q.size(), 16);
    m_ready_i = 1'b1;
    begin
      int n = 0;
      while (q.size() != 0 && n < 60) begin
        tick();
        n++;
      end
    end
    check("t4_drain_done", q.size(), 0);
    tick();
    check("t4_empty", m_valid_o, 0);
    check("t4_ovf_sticky", overflow_o, 1);

    // Byte during FLUSH dropped, repeated flush ignored
    do_reset();
    check("t5_ovf_cleared", overflow_o, 0);
    m_ready_i = 1'b1;
    send_byte(0, 8'h55);
    do_flush();
    valid_i = 1'b1;
    enc_i   = 8'h99;
    lane_i  = 2'd2;
    flush_i = 1'b1;
    tick();
    valid_i = 1'b0;
    flush_i = 1'b0;
    check("t5_ovf", overflow_o, 1);
    wait_not_busy("t5_busy_fall");
    repeat (6) tick();
    check("t5_drained", q.size(), 0);
    check("t5_idle", busy_o, 0);

    // Reset during FLUSH with FIFO non-empty
    do_reset();
    m_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(1, 8'(8'hC0 + i));
    send_byte(0, 8'hD0);
    do_flush();
    valid_i = 1'b1;
    enc_i   = 8'h77;
    lane_i  = 2'd3;
    tick();
    valid_i = 1'b0;
    check("t6_pre_busy", busy_o, 1);
    check("t6_pre_ovf", overflow_o, 1);
    check("t6_pre_valid", m_valid_o, 1);
    rst_i = 1'b1;
    #1;
    check("t6_rst_valid", m_valid_o, 0);
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_ovf", overflow_o, 0);
    model_clear();
    tick();
    rst_i = 1'b0;
    m_ready_i = 1'b1;
    send_byte(0, 8'hA1);
    send_byte(0, 8'hA2);
    send_byte(0, 8'hA3);
    send_byte(0, 8'hA4);
    check("t6_word_valid", m_valid_o, 1);
    repeat (3) tick();
    check("t6_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
